// File: rtl/calib_sweep_ctrl_if.sv
// Bundle of calibration control, ADC input and servo step signals.
// master: the environment (starts calibration, supplies ADC samples).
// slave: the calibration controller.
interface calib_sweep_ctrl_if #(
  parameter int unsigned AdcW = 8,
  parameter int unsigned CntW = 4
);
  logic            start;
  logic            adc_valid;
  logic [AdcW-1:0] adc_data;
  logic            step_cw_h;
  logic            step_ccw_h;
  logic            step_cw_v;
  logic            step_ccw_v;
  logic            busy;
  logic            done;
  logic [AdcW-1:0] max_h;
  logic [AdcW-1:0] max_v;
  logic [CntW-1:0] back_cnt;

  modport master (
    output start, adc_valid, adc_data,
    input  step_cw_h, step_ccw_h, step_cw_v, step_ccw_v, busy, done, max_h, max_v, back_cnt
  );

  modport slave (
    input  start, adc_valid, adc_data,
    output step_cw_h, step_ccw_h, step_cw_v, step_ccw_v, busy, done, max_h, max_v, back_cnt
  );
endinterface

// File: rtl/calib_sweep_ctrl.sv
// Tracker calibration sequencer: sweeps the H servo then the V servo, tracks the
// peak ADC sample and the steps taken since it, then steps each servo back to its
// peak. All outputs come straight from registers.
module calib_sweep_ctrl #(
  parameter int unsigned SweepSteps = 8,
  parameter int unsigned CntW       = 4,
  parameter int unsigned AdcW       = 8,
  parameter int unsigned StepDiv    = 2
) (
  input logic               clk,
  input logic               reset,
  calib_sweep_ctrl_if.slave bus
);

  localparam int unsigned SetW = (StepDiv > 1) ? $clog2(StepDiv) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(SweepSteps - 1);
  localparam logic [SetW-1:0] SetLast = SetW'(StepDiv - 1);

  typedef enum logic [3:0] {
    StIdle,
    StHSample,
    StHSettle,
    StHReturn,
    StHRwait,
    StVSample,
    StVSettle,
    StVReturn,
    StVRwait,
    StFin
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] step_idx_q, step_idx_d;
  logic [SetW-1:0] settle_q, settle_d;
  logic [AdcW-1:0] peak_q, peak_d;
  logic [CntW-1:0] back_q, back_d;
  logic [AdcW-1:0] max_h_q, max_h_d;
  logic [AdcW-1:0] max_v_q, max_v_d;
  logic            cw_h_q, cw_h_d;
  logic            ccw_h_q, ccw_h_d;
  logic            cw_v_q, cw_v_d;
  logic            ccw_v_q, ccw_v_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Axis currently being swept; lets H and V share one set of case arms.
  logic is_v;
  assign is_v = state_q inside {StVSample, StVSettle, StVReturn, StVRwait};

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    settle_d   = settle_q;
    peak_d     = peak_q;
    back_d     = back_q;
    max_h_d    = max_h_q;
    max_v_d    = max_v_q;
    cw_h_d     = 1'b0;
    ccw_h_d    = 1'b0;
    cw_v_d     = 1'b0;
    ccw_v_d    = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StHSample;
          step_idx_d = '0;
          back_d     = '0;
        end
      end

      StHSample, StVSample: begin
        if (bus.adc_valid) begin
          // Strict compare keeps the earliest position on ties.
          if (step_idx_q == '0 || bus.adc_data > peak_q) begin
            peak_d = bus.adc_data;
            back_d = '0;
          end else if (back_q != {CntW{1'b1}}) begin
            back_d = back_q + 1'b1;
          end
          if (step_idx_q == LastIdx) begin
            state_d = is_v ? StVReturn : StHReturn;
          end else begin
            cw_h_d     = ~is_v;
            cw_v_d     = is_v;
            step_idx_d = step_idx_q + 1'b1;
            settle_d   = '0;
            state_d    = is_v ? StVSettle : StHSettle;
          end
        end
      end

      StHSettle, StVSettle: begin
        if (settle_q == SetLast) begin
          settle_d = '0;
          state_d  = is_v ? StVSample : StHSample;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      StHReturn, StVReturn: begin
        if (back_q == '0) begin
          if (is_v) begin
            max_v_d = peak_q;
            done_d  = 1'b1;
            state_d = StFin;
          end else begin
            max_h_d    = peak_q;
            step_idx_d = '0;
            state_d    = StVSample;
          end
        end else begin
          ccw_h_d  = ~is_v;
          ccw_v_d  = is_v;
          back_d   = back_q - 1'b1;
          settle_d = '0;
          state_d  = is_v ? StVRwait : StHRwait;
        end
      end

      StHRwait, StVRwait: begin
        if (settle_q == SetLast) begin
          settle_d = '0;
          state_d  = is_v ? StVReturn : StHReturn;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      step_idx_q <= '0;
      settle_q   <= '0;
      peak_q     <= '0;
      back_q     <= '0;
      max_h_q    <= '0;
      max_v_q    <= '0;
      cw_h_q     <= 1'b0;
      ccw_h_q    <= 1'b0;
      cw_v_q     <= 1'b0;
      ccw_v_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      settle_q   <= settle_d;
      peak_q     <= peak_d;
      back_q     <= back_d;
      max_h_q    <= max_h_d;
      max_v_q    <= max_v_d;
      cw_h_q     <= cw_h_d;
      ccw_h_q    <= ccw_h_d;
      cw_v_q     <= cw_v_d;
      ccw_v_q    <= ccw_v_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.step_cw_h  = cw_h_q;
  assign bus.step_ccw_h = ccw_h_q;
  assign bus.step_cw_v  = cw_v_q;
  assign bus.step_ccw_v = ccw_v_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.max_h      = max_h_q;
  assign bus.max_v      = max_v_q;
  assign bus.back_cnt   = back_q;

endmodule

// File: tb/tb_calib_sweep_ctrl.sv
// Scoreboard bench for calib_sweep_ctrl: each calibration pushes its expected peaks
// and return-step counts; a monitor counts step pulses and checks at every DONE.
module tb_calib_sweep_ctrl;
  localparam int unsigned SweepSteps = 8;
  localparam int unsigned CntW       = 4;
  localparam int unsigned AdcW       = 8;
  localparam int unsigned StepDiv    = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  calib_sweep_ctrl_if #(.AdcW(AdcW), .CntW(CntW)) bus ();

  calib_sweep_ctrl #(
    .SweepSteps(SweepSteps),
    .CntW      (CntW),
    .AdcW      (AdcW),
    .StepDiv   (StepDiv)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef logic [AdcW-1:0] sweep_t[SweepSteps];
  typedef struct {
    int max_h;
    int max_v;
    int ccw_h;
    int ccw_v;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Peak is the first maximum; every later position costs one step back.
  function automatic void model(input sweep_t s, output int pk, output int ccw);
    int idx;
    pk  = -1;
    idx = 0;
    for (int i = 0; i < int'(SweepSteps); i++) begin
      if (int'(s[i]) > pk) begin
        pk  = int'(s[i]);
        idx = i;
      end
    end
    ccw = int'(SweepSteps) - 1 - idx;
    if (ccw > (2 ** CntW) - 1) ccw = (2 ** CntW) - 1;
  endfunction

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   n_cw_h, n_cw_v, n_ccw_h, n_ccw_v;
  int   last_ccw_h, last_ccw_v;
  bit   done_prev;
  exp_t e;

  task automatic clear_counts();
    n_cw_h = 0; n_cw_v = 0; n_ccw_h = 0; n_ccw_v = 0;
    last_ccw_h = -1; last_ccw_v = -1;
  endtask

  initial begin
    clear_counts();
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        clear_counts();
        done_prev = 1'b0;
      end else begin
        check("one_step_at_a_time",
              int'($countones({bus.step_cw_h, bus.step_ccw_h, bus.step_cw_v, bus.step_ccw_v}) <= 1),
              1);
        if (bus.step_cw_h) n_cw_h++;
        if (bus.step_cw_v) n_cw_v++;
        if (bus.step_ccw_h) begin
          if (last_ccw_h >= 0) check("ccw_h_spacing", cyc - last_ccw_h, StepDiv + 1);
          last_ccw_h = cyc;
          n_ccw_h++;
        end
        if (bus.step_ccw_v) begin
          if (last_ccw_v >= 0) check("ccw_v_spacing", cyc - last_ccw_v, StepDiv + 1);
          last_ccw_v = cyc;
          n_ccw_v++;
        end
        if (done_prev) begin
          check("busy_after_done", int'(bus.busy), 0);
          check("done_one_cycle", int'(bus.done), 0);
        end
        if (bus.done) begin
          check("busy_in_fin", int'(bus.busy), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("max_h", int'(bus.max_h), e.max_h);
            check("max_v", int'(bus.max_v), e.max_v);
            check("cw_h_count", n_cw_h, SweepSteps - 1);
            check("cw_v_count", n_cw_v, SweepSteps - 1);
            check("ccw_h_count", n_ccw_h, e.ccw_h);
            check("ccw_v_count", n_ccw_v, e.ccw_v);
          end
          clear_counts();
        end
        done_prev = bus.done;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic recover();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.adc_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_steps"},
          int'({bus.step_cw_h, bus.step_ccw_h, bus.step_cw_v, bus.step_ccw_v}), 0);
    check({tag, "_max_h"}, int'(bus.max_h), 0);
    check({tag, "_max_v"}, int'(bus.max_v), 0);
    check({tag, "_back_cnt"}, int'(bus.back_cnt), 0);
  endtask

  // DUT sits in x_SAMPLE: random idle gap (START pulses ignored), then one valid beat.
  task automatic feed_sample(input logic [AdcW-1:0] d);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      bus.adc_valid = 1'b0;
      bus.adc_data  = AdcW'($urandom);
      bus.start     = 1'($urandom);
      tick();
    end
    bus.adc_valid = 1'b1;
    bus.adc_data  = d;
    bus.start     = 1'b0;
    tick();
    bus.adc_valid = 1'b0;
  endtask

  // DUT sits in x_SETTLE: decoy samples and START must have no effect.
  task automatic settle_decoy();
    repeat (StepDiv) begin
      bus.adc_valid = 1'($urandom);
      bus.adc_data  = AdcW'($urandom);
      bus.start     = 1'($urandom);
      tick();
    end
    bus.adc_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic feed_sweep(input sweep_t s, input int first);
    for (int i = first; i < int'(SweepSteps); i++) begin
      feed_sample(s[i]);
      if (i < int'(SweepSteps) - 1) settle_decoy();
    end
  endtask

  task automatic run_cal(input sweep_t h, input sweep_t v);
    exp_t x;
    bit   ok;
    model(h, x.max_h, x.ccw_h);
    model(v, x.max_v, x.ccw_v);
    exp_q.push_back(x);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    feed_sweep(h, 0);

    // H return length is unknown here: offer v[0] until the first V step appears.
    ok = 1'b0;
    bus.adc_data = v[0];
    for (int t = 0; t < 200 && !ok; t++) begin
      bus.adc_valid = 1'($urandom);
      tick();
      ok = bus.step_cw_v;
    end
    bus.adc_valid = 1'b0;
    if (!ok) begin
      check("wait_first_cw_v", 0, 1);
      recover();
      return;
    end
    settle_decoy();
    feed_sweep(v, 1);

    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      tick();
      ok = bus.done;
    end
    if (!ok) begin
      check("wait_done", 0, 1);
      recover();
      return;
    end
    repeat ($urandom_range(1, 3)) tick();
  endtask

  function automatic sweep_t rand_sweep();
    sweep_t s;
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < int'(SweepSteps); i++) begin
      case (mode)
        0:       s[i] = AdcW'($urandom_range(0, 7));
        1:       s[i] = AdcW'($urandom);
        default: s[i] = AdcW'(8'd77);
      endcase
    end
    return s;
  endfunction

  initial begin : stim
    sweep_t h, v;
    bit     quiet;
    bus.start     = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;

    reset = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    quiet = 1'b1;
    repeat (5) begin
      tick();
      if (bus.busy || bus.step_cw_h || bus.step_ccw_h || bus.step_cw_v || bus.step_ccw_v)
        quiet = 1'b0;
    end
    check("idle_without_start", int'(quiet), 1);

    h = '{8'd10, 8'd20, 8'd50, 8'd30, 8'd30, 8'd30, 8'd30, 8'd30};
    run_cal(h, rand_sweep());
    h = '{8'd5, 8'd40, 8'd7, 8'd7, 8'd40, 8'd1, 8'd1, 8'd1};
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    run_cal(h, v);
    h = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_cal(h, rand_sweep());

    // Abort during H_RWAIT: peak at 0 forces a return with several steps.
    h = '{8'd200, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    feed_sweep(h, 0);
    tick();
    check("ccw_h_before_abort", int'(bus.step_ccw_h), 1);
    reset = 1'b1;
    tick();
    check_all_zero("abort");
    reset = 1'b0;
    quiet = 1'b1;
    repeat (12) begin
      bus.adc_valid = 1'($urandom);
      bus.adc_data  = AdcW'($urandom);
      tick();
      if (bus.busy || bus.step_cw_h || bus.step_ccw_h || bus.step_cw_v || bus.step_ccw_v)
        quiet = 1'b0;
    end
    bus.adc_valid = 1'b0;
    check("quiet_after_abort", int'(quiet), 1);

    for (int r = 0; r < 15; r++) run_cal(rand_sweep(), rand_sweep());

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
